// File: rtl/baopoco_quant_gain_apply.sv
// Applies a double-buffered quantiser gain to a complex sample stream and requantises
// each component to a symmetric signed OUT_W-bit value, counting saturated samples.
module baopoco_quant_gain_apply #(
    parameter int unsigned DIN_W     = 18,
    parameter int unsigned GAIN_W    = 16,
    parameter int unsigned GAIN_FRAC = 10,
    parameter int unsigned OUT_W     = 4
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    input  logic [31:0]             gain_reg,
    input  logic                    sync_in,
    input  logic                    din_valid,
    input  logic signed [DIN_W-1:0] din_re,
    input  logic signed [DIN_W-1:0] din_im,
    input  logic                    sat_clr,
    output logic                    dout_valid,
    output logic signed [OUT_W-1:0] dout_re,
    output logic signed [OUT_W-1:0] dout_im,
    output logic [2*OUT_W-1:0]      dout_packed,
    output logic                    sync_out,
    output logic [31:0]             sat_count
);

    localparam int unsigned PW = DIN_W + GAIN_W + 1;
    localparam int unsigned SH = (DIN_W - 1) + GAIN_FRAC - (OUT_W - 1);
    localparam int unsigned RW = PW + 1;
    localparam int unsigned QW = RW - SH;

    localparam logic signed [RW-1:0] Half = RW'(2 ** (SH - 1));
    localparam logic signed [QW-1:0] QMax = QW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [QW-1:0] QMin = -QMax;

    logic [GAIN_W-1:0]        gain_active;
    logic [GAIN_W-1:0]        s1_gain;
    logic signed [DIN_W-1:0]  s1_re, s1_im;
    logic                     s1_valid, s1_sync;
    logic signed [PW-1:0]     p_re, p_im;
    logic                     s2_valid, s2_sync;
    logic signed [GAIN_W:0]   gain_s;
    logic signed [RW-1:0]     sum_re, sum_im;
    logic signed [QW-1:0]     q_re, q_im;
    logic signed [OUT_W-1:0]  c_re, c_im;
    logic                     sat_re, sat_im;
    logic                     unused_gain_hi;

    assign unused_gain_hi = ^gain_reg[31:GAIN_W];
    assign gain_s         = {1'b0, s1_gain};

    // Stage 1 captures the pre-update gain, so a sample coincident with sync uses the old one.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            gain_active <= '0;
            s1_gain     <= '0;
            s1_re       <= '0;
            s1_im       <= '0;
            s1_valid    <= 1'b0;
            s1_sync     <= 1'b0;
        end else begin
            if (sync_in) begin
                gain_active <= gain_reg[GAIN_W-1:0];
            end
            s1_gain  <= gain_active;
            s1_re    <= din_re;
            s1_im    <= din_im;
            s1_valid <= din_valid;
            s1_sync  <= sync_in;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            p_re     <= '0;
            p_im     <= '0;
            s2_valid <= 1'b0;
            s2_sync  <= 1'b0;
        end else begin
            p_re     <= PW'(s1_re) * PW'(gain_s);
            p_im     <= PW'(s1_im) * PW'(gain_s);
            s2_valid <= s1_valid;
            s2_sync  <= s1_sync;
        end
    end

    // Round half toward +inf, then clamp symmetrically so the most negative code never appears.
    always_comb begin
        sum_re = RW'(p_re) + Half;
        sum_im = RW'(p_im) + Half;
        q_re   = sum_re[RW-1:SH];
        q_im   = sum_im[RW-1:SH];
        sat_re = 1'b0;
        sat_im = 1'b0;
        c_re   = q_re[OUT_W-1:0];
        c_im   = q_im[OUT_W-1:0];
        if (q_re > QMax) begin
            c_re   = QMax[OUT_W-1:0];
            sat_re = 1'b1;
        end else if (q_re < QMin) begin
            c_re   = QMin[OUT_W-1:0];
            sat_re = 1'b1;
        end
        if (q_im > QMax) begin
            c_im   = QMax[OUT_W-1:0];
            sat_im = 1'b1;
        end else if (q_im < QMin) begin
            c_im   = QMin[OUT_W-1:0];
            sat_im = 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            dout_valid  <= 1'b0;
            dout_re     <= '0;
            dout_im     <= '0;
            dout_packed <= '0;
            sync_out    <= 1'b0;
            sat_count   <= '0;
        end else begin
            dout_valid <= s2_valid;
            sync_out   <= s2_sync;
            if (s2_valid) begin
                dout_re     <= c_re;
                dout_im     <= c_im;
                dout_packed <= {c_re, c_im};
            end
            if (sat_clr) begin
                sat_count <= '0;
            end else if (s2_valid && (sat_re || sat_im) && (sat_count != 32'hFFFF_FFFF)) begin
                sat_count <= sat_count + 32'd1;
            end
        end
    end

endmodule
